// File: rtl/trojan_trigger_gen.sv
// trojan_trigger_gen
// Counts qualified events on a monitored bus and, once THRESH events have
// been seen, enters an ACTIVE phase in which a toggle register rotates every
// cycle and trig is held high. The ACTIVE phase either latches until reset
// (STICKY=1) or lasts ACTIVE_CYC cycles before re-arming (STICKY=0).
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   en       event qualification enable
//   out      monitored data bus (DATA_W)
//   trig     trigger active, registered
//   tog_q    toggle register contents (TOG_W)
//   evt_cnt  current event count (CNT_W)
module trojan_trigger_gen #(
  parameter int unsigned       DATA_W     = 128,
  parameter int unsigned       CNT_W      = 32,
  parameter logic [CNT_W-1:0]  THRESH     = {CNT_W{1'b1}},
  parameter int unsigned       MODE       = 0,
  parameter logic [DATA_W-1:0] MATCH      = '0,
  parameter bit                STICKY     = 1'b1,
  parameter logic [CNT_W-1:0]  ACTIVE_CYC = CNT_W'(256),
  parameter int unsigned       TOG_W      = 128,
  parameter logic [TOG_W-1:0]  TOG_SEED   = {(TOG_W/2){2'b10}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] out,
  output logic              trig,
  output logic [TOG_W-1:0]  tog_q,
  output logic [CNT_W-1:0]  evt_cnt
);

  typedef enum logic {S_COUNT = 1'b0, S_ACTIVE = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH_M1 = THRESH - CNT_ONE;
  localparam logic [CNT_W-1:0] ACT_M1    = ACTIVE_CYC - CNT_ONE;

  state_e            state_q;
  logic              trig_q;
  logic              valid_q;
  logic [DATA_W-1:0] out_q;
  logic [CNT_W-1:0]  evt_cnt_q;
  logic [CNT_W-1:0]  dur_cnt_q;
  logic              evt_d;

  // Change mode needs one registered sample before a comparison is
  // meaningful; match mode compares against a constant and needs no history.
  always_comb begin
    evt_d = 1'b0;
    if (MODE == 0) evt_d = en && valid_q && (out != out_q);
    else           evt_d = en && (out == MATCH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_COUNT;
      trig_q    <= 1'b0;
      valid_q   <= 1'b0;
      out_q     <= '0;
      evt_cnt_q <= '0;
      dur_cnt_q <= '0;
      tog_q     <= TOG_SEED;
    end else begin
      // Bus history keeps tracking in every state so a re-armed trigger
      // compares against the previous cycle, not a stale value.
      out_q   <= out;
      valid_q <= 1'b1;
      case (state_q)
        S_COUNT: begin
          if (evt_d) begin
            // Fire on the THRESH-th event; the counter never reaches THRESH.
            if (evt_cnt_q == THRESH_M1) begin
              state_q   <= S_ACTIVE;
              trig_q    <= 1'b1;
              evt_cnt_q <= '0;
              dur_cnt_q <= '0;
            end else begin
              evt_cnt_q <= evt_cnt_q + CNT_ONE;
            end
          end
        end
        S_ACTIVE: begin
          tog_q     <= {tog_q[0], tog_q[TOG_W-1:1]};
          evt_cnt_q <= '0;
          if (!STICKY) begin
            // Return edge is still an ACTIVE cycle: events here are dropped.
            if (dur_cnt_q == ACT_M1) begin
              state_q   <= S_COUNT;
              trig_q    <= 1'b0;
              dur_cnt_q <= '0;
            end else begin
              dur_cnt_q <= dur_cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_q <= S_COUNT;
          trig_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trig    = trig_q;
  assign evt_cnt = evt_cnt_q;

endmodule

// File: doc/trojan_trigger_gen.md
TROJAN_TRIGGER_GEN -- requirements
Module: trojan_trigger_gen

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
  DATA_W, 128, width of monitored bus
  CNT_W, 32, event and duration counter width
  THRESH, 2**CNT_W-1, event count that fires trigger (legal range 1..2**CNT_W-1)
  MODE, 0, 0 = count bus changes, 1 = count pattern matches
  MATCH, 0, DATA_W-bit pattern used when MODE=1
  STICKY, 1, 1 = trigger latches until reset, 0 = re-arms after ACTIVE_CYC
  ACTIVE_CYC, 256, payload duration in cycles when STICKY=0 (range 1..2**CNT_W-1)
  TOG_W, 128, toggle register width
  TOG_SEED, alternating 1010... pattern (AA..AA), toggle register reset value
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk  input  1  single clock; all state updates on rising edge
  rst  input  1  reset, asynchronous, active-low
  en  input  1  event qualification enable
  out  input  DATA_W  monitored data bus
  trig  output  1  trigger active
  tog_q  output  TOG_W  toggle register contents
  evt_cnt  output  CNT_W  current event count

Function
REQ-003 out_q SHALL register out every cycle; valid_q SHALL be set on the first edge after reset release and stay set.
REQ-004 When MODE=0, an event SHALL be en && valid_q && (out != out_q).
REQ-005 When MODE=1, an event SHALL be en && (out == MATCH); valid_q SHALL be ignored.
REQ-006 The FSM SHALL have two states: COUNT and ACTIVE.
REQ-007 trig SHALL equal 1 exactly when the state is ACTIVE, driven from a register.
REQ-008 In COUNT, each event SHALL increment evt_cnt by 1.
REQ-009 In COUNT, if an event occurs while evt_cnt == THRESH-1, then on that edge the state SHALL go to ACTIVE and evt_cnt SHALL load 0, so trig rises one cycle after the sampled event.
REQ-010 evt_cnt SHALL never wrap, because THRESH-1 is its maximum value in COUNT.
REQ-011 With en low in COUNT, evt_cnt and the state SHALL hold.
REQ-012 In ACTIVE, events SHALL be ignored, evt_cnt SHALL hold 0, and en SHALL have no effect.
REQ-013 In ACTIVE, tog_q SHALL rotate right by one bit every cycle: {tog_q[0], tog_q[TOG_W-1:1]}.
REQ-014 In COUNT, tog_q SHALL hold its value.
REQ-015 On re-arm, tog_q SHALL not be reloaded with TOG_SEED.
REQ-016 When STICKY=1, ACTIVE SHALL persist until reset.
REQ-017 When STICKY=0, the duration counter dur_cnt SHALL clear on entry to ACTIVE and increment each ACTIVE cycle.
REQ-018 When STICKY=0, on the edge where dur_cnt == ACTIVE_CYC-1, the state SHALL return to COUNT, so trig is high for exactly ACTIVE_CYC cycles.
REQ-019 An event sampled on the return edge of REQ-018 SHALL not be counted.
REQ-020 When THRESH=1, the first qualifying event SHALL fire the trigger.
REQ-021 out_q SHALL keep tracking out in every state, so no change event is lost or stale after re-arm.

Reset
REQ-022 While rst=0, all state SHALL take its reset value immediately, regardless of clk.
REQ-023 The reset values SHALL be: state=COUNT, trig=0, evt_cnt=0, dur_cnt=0, tog_q=TOG_SEED, out_q=0, valid_q=0.
REQ-024 Reset asserted mid-count or mid-ACTIVE SHALL abort the operation.
REQ-025 After reset, no event SHALL be counted before the first post-release edge when MODE=0.

Verification
REQ-026 The bench SHALL use DATA_W=8, CNT_W=4, THRESH=4, TOG_W=8, TOG_SEED=8'hAA for the directed scenarios below.
REQ-027 MODE=0, STICKY=1: toggle out 00->01->02->03->04 with en=1 -> evt_cnt steps 1,2,3; trig rises the cycle after the 4th change; tog_q goes AA,55,AA,... each cycle; stays high for 20+ cycles.
REQ-028 MODE=0, out held constant for 10 cycles, then one change with en=0 -> evt_cnt stays 0; trig stays 0.
REQ-029 MODE=1, MATCH=8'h5A, STICKY=0, ACTIVE_CYC=3: drive 5A for 4 cycles -> trig high for exactly 3 cycles; tog_q AA->55->AA->55 then holds 55; evt_cnt=0 on return; 4 more matches re-fire and tog_q continues from 55.
REQ-030 Reset pulse of under half a clock during ACTIVE -> trig=0 and tog_q=AA asynchronously; the first post-release out change is not counted; the next 4 changes re-fire the trigger.
REQ-031 THRESH=1, MODE=1 -> the first match drives trig=1 on the next cycle.
